button_event: RTL and testbench
===============================

Name: button_event

Overview:
- Consumes the debounced level produced by the debounce stage and classifies each activity burst into discrete user events: press, short click, long press and double click.
- Emits one-cycle event pulses plus a wrapping event counter for downstream control logic such as mode selection and LED/display drivers.
- Single-clock block. No clock-domain crossing: the input is already synchronous and glitch-free.

Parameters:
- LONG_PRESS_TIME, 50_000_000, hold duration in clock cycles that qualifies a long press (1 s at 50 MHz).
- DOUBLE_CLICK_TIME, 15_000_000, maximum gap in cycles between first release and second press for a double click.
- REPEAT_TIME, 10_000_000, auto-repeat period in cycles; used only with BUTTON_EVENT_AUTO_REPEAT_EN.
- CNT_WIDTH, 32, width of the internal timing counter. Must hold max(LONG_PRESS_TIME, DOUBLE_CLICK_TIME, REPEAT_TIME).

Ports:
- clk_i  input  1  system clock. One clock; reset is synchronous and active-high.
- rst_i  input  1  synchronous, active-high reset.
- signal_i  input  1  debounced button level, 1 = pressed.
- press_o  output  1  one-cycle pulse on every accepted press edge.
- short_o  output  1  one-cycle pulse: single click completed.
- long_o  output  1  one-cycle pulse: hold reached LONG_PRESS_TIME.
- double_o  output  1  one-cycle pulse: double click completed.
- repeat_o  output  1  one-cycle auto-repeat pulse (0 when feature is compiled out).
- held_o  output  1  level, 1 while in any pressed state.
- event_cnt_o  output  8  count of short+long+double events, wraps 255 -> 0.

Behaviour:
- All outputs are registered. On the clock edge with rst_i=1:
  - state <- ST_IDLE, timing counter <- 0.
  - All pulses, held_o and event_cnt_o <- 0.
  - Edge register sig_q <- 1, so a button held through reset produces no press until it is released and pressed again.
- Edge detect: rise = signal_i & ~sig_q; fall = ~signal_i & sig_q.
- Latency: press_o is high in cycle N+1, where N is the first cycle signal_i is sampled high after a low. The same rule applies to every other pulse: one cycle after its trigger condition.
- FSM states: ST_IDLE, ST_PRESSED, ST_LONG, ST_WAIT_SECOND, ST_SECOND_PRESSED.
- ST_IDLE:
  - rise -> ST_PRESSED, counter <- 0, press_o pulse.
- ST_PRESSED:
  - Counter increments every cycle.
  - fall -> ST_WAIT_SECOND, counter <- 0.
  - Otherwise, counter == LONG_PRESS_TIME-1 -> ST_LONG, long_o pulse. Result: long_o comes exactly LONG_PRESS_TIME cycles after press_o.
- ST_LONG:
  - fall -> ST_IDLE. No short_o, no double_o.
- ST_WAIT_SECOND:
  - Counter increments every cycle.
  - rise -> ST_SECOND_PRESSED, press_o pulse.
  - Else counter == DOUBLE_CLICK_TIME-1 -> ST_IDLE, short_o pulse.
  - Rise and timeout in the same cycle: rise wins, so it becomes a double click.
- ST_SECOND_PRESSED:
  - fall -> ST_IDLE, double_o pulse, regardless of hold length. No long_o in this state.
- held_o = 1 in ST_PRESSED, ST_LONG and ST_SECOND_PRESSED.
- At most one of short_o, long_o, double_o is high in any cycle.
- event_cnt_o increments by 1 in the same cycle any of short_o, long_o or double_o pulses.
- Counter comparisons use equality on CNT_WIDTH bits. The counter never wraps inside a state because every counting state exits at its limit.
- Reset mid-operation (any state) aborts the gesture; no event is emitted for it.

Optional Feature:
- Macro: BUTTON_EVENT_AUTO_REPEAT_EN.
- Defined:
  - In ST_LONG a second counter, reset to 0 on entry, increments.
  - At REPEAT_TIME-1 it pulses repeat_o and reloads to 0.
  - First repeat_o comes REPEAT_TIME cycles after long_o; repeats continue until release.
  - repeat_o does not affect event_cnt_o.
- Undefined: repeat logic is absent and repeat_o is tied to 0. The port remains so instantiations are unchanged.

Test Plan (LONG_PRESS_TIME=10, DOUBLE_CLICK_TIME=6, REPEAT_TIME=4):
- Press for 3 cycles, then release -> press_o 1 cycle after rise; short_o exactly 6 cycles after release is registered; event_cnt_o=1; no long_o or double_o.
- Hold for 20 cycles -> long_o exactly 10 cycles after press_o; release gives no short_o; event_cnt_o=1. With the macro defined, repeat_o at +4 and +8 after long_o.
- Press 2, release 3, press 2, release -> two press_o pulses; double_o 1 cycle after second release; no short_o; event_cnt_o=1.
- Second rise on the exact timeout cycle of ST_WAIT_SECOND -> double_o path taken, short_o never asserted.
- Assert rst_i while in ST_PRESSED with signal_i held high, deassert while still high -> all outputs 0; no press_o until release and re-press.
- Run 256 short clicks -> event_cnt_o wraps to 0.

Source files
------------

// File: rtl/button_event.sv
// button_event: classifies bursts of a debounced button level into press,
// short click, long press and double click pulses, and keeps a wrapping
// 8-bit count of completed short/long/double events.
// Optional auto-repeat while a long press is held is compiled in when the
// macro BUTTON_EVENT_AUTO_REPEAT_EN is defined; otherwise repeat_o is tied low.
module button_event #(
  parameter int unsigned LONG_PRESS_TIME   = 50_000_000,
  parameter int unsigned DOUBLE_CLICK_TIME = 15_000_000,
  parameter int unsigned REPEAT_TIME       = 10_000_000,
  parameter int unsigned CNT_WIDTH         = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       signal_i,
  output logic       press_o,
  output logic       short_o,
  output logic       long_o,
  output logic       double_o,
  output logic       repeat_o,
  output logic       held_o,
  output logic [7:0] event_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG,
    ST_WAIT_SECOND,
    ST_SECOND_PRESSED
  } state_t;

  localparam int unsigned MAX_LP_DC =
    (LONG_PRESS_TIME > DOUBLE_CLICK_TIME) ? LONG_PRESS_TIME : DOUBLE_CLICK_TIME;
  localparam int unsigned MAX_TIME  =
    (MAX_LP_DC > REPEAT_TIME) ? MAX_LP_DC : REPEAT_TIME;
  localparam bit CFG_OK = (LONG_PRESS_TIME > 0) && (DOUBLE_CLICK_TIME > 0) &&
                          (REPEAT_TIME > 0) && ((MAX_TIME >> CNT_WIDTH) == 0);

  // Refuse to elaborate with zero timings or a counter too narrow for them.
  if (!CFG_OK) begin : g_bad_cfg
    $error("button_event: timing parameters must be non-zero and fit in CNT_WIDTH bits");
  end

  localparam logic [CNT_WIDTH-1:0] LONG_LIM = CNT_WIDTH'(LONG_PRESS_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] DBL_LIM  = CNT_WIDTH'(DOUBLE_CLICK_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sig_q;
  logic                 rise, fall;

  logic                 press_d, short_d, long_d, double_d, held_d;
  logic [7:0]           event_cnt_d;

  // Edge detection against the previous sampled level.
  always_comb begin
    rise = signal_i & ~sig_q;
    fall = ~signal_i & sig_q;
  end

  // State, timing counter, edge register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sig_q       <= 1'b1;
      press_o     <= 1'b0;
      short_o     <= 1'b0;
      long_o      <= 1'b0;
      double_o    <= 1'b0;
      held_o      <= 1'b0;
      event_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sig_q       <= signal_i;
      press_o     <= press_d;
      short_o     <= short_d;
      long_o      <= long_d;
      double_o    <= double_d;
      held_o      <= held_d;
      event_cnt_o <= event_cnt_d;
    end
  end

  // Next-state and timing-counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          state_d = ST_WAIT_SECOND;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LIM) begin
          state_d = ST_LONG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LONG: begin
        if (fall) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_WAIT_SECOND: begin
        // A rise on the timeout cycle still counts as the second press.
        if (rise) begin
          state_d = ST_SECOND_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DBL_LIM) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_SECOND_PRESSED: begin
        if (fall) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulse, held-level and event-count next values (registered above).
  always_comb begin
    press_d  = rise && ((state_q == ST_IDLE) || (state_q == ST_WAIT_SECOND));
    long_d   = (state_q == ST_PRESSED) && !fall && (cnt_q == LONG_LIM);
    short_d  = (state_q == ST_WAIT_SECOND) && !rise && (cnt_q == DBL_LIM);
    double_d = (state_q == ST_SECOND_PRESSED) && fall;
    held_d   = (state_d == ST_PRESSED) || (state_d == ST_LONG) ||
               (state_d == ST_SECOND_PRESSED);
    event_cnt_d = event_cnt_o;
    if (short_d || long_d || double_d) begin
      event_cnt_d = event_cnt_o + 8'd1;
    end
  end

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  localparam logic [CNT_WIDTH-1:0] REP_LIM = CNT_WIDTH'(REPEAT_TIME - 1);

  logic [CNT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
  logic                 rep_fire;

  // Repeat counter runs only while in ST_LONG and stays zero elsewhere,
  // so it is already cleared on every entry into ST_LONG.
  always_comb begin
    rep_fire  = (state_q == ST_LONG) && !fall && (rep_cnt_q == REP_LIM);
    rep_cnt_d = '0;
    if ((state_q == ST_LONG) && !fall && !rep_fire) begin
      rep_cnt_d = rep_cnt_q + CNT_ONE;
    end
  end

  // Repeat counter and registered repeat pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rep_cnt_q <= '0;
      repeat_o  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      repeat_o  <= rep_fire;
    end
  end
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Directed testbench for button_event with LONG_PRESS_TIME=10,
// DOUBLE_CLICK_TIME=6, REPEAT_TIME=4. Works with or without
// BUTTON_EVENT_AUTO_REPEAT_EN defined.
module tb_button_event;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       signal_i = 1'b0;
  logic       press_o, short_o, long_o, double_o, repeat_o, held_o;
  logic [7:0] event_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int multi_hot = 0;

  int press_q[$];
  int short_q[$];
  int long_q[$];
  int double_q[$];
  int repeat_q[$];

  button_event #(
    .LONG_PRESS_TIME  (10),
    .DOUBLE_CLICK_TIME(6),
    .REPEAT_TIME      (4),
    .CNT_WIDTH        (32)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .signal_i   (signal_i),
    .press_o    (press_o),
    .short_o    (short_o),
    .long_o     (long_o),
    .double_o   (double_o),
    .repeat_o   (repeat_o),
    .held_o     (held_o),
    .event_cnt_o(event_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock edge, then log which pulses are visible after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    if (press_o === 1'b1)  press_q.push_back(cyc);
    if (short_o === 1'b1)  short_q.push_back(cyc);
    if (long_o === 1'b1)   long_q.push_back(cyc);
    if (double_o === 1'b1) double_q.push_back(cyc);
    if (repeat_o === 1'b1) repeat_q.push_back(cyc);
    if ((int'(short_o) + int'(long_o) + int'(double_o)) > 1) multi_hot++;
  endtask

  task automatic clear_log();
    press_q.delete();
    short_q.delete();
    long_q.delete();
    double_q.delete();
    repeat_q.delete();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    signal_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    clear_log();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    signal_i = 1'b0;
    repeat (3) tick();
    checks++;
    if ({press_o, short_o, long_o, double_o, repeat_o, held_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b, expected 000000",
               {press_o, short_o, long_o, double_o, repeat_o, held_o});
    end
    checks++;
    if (event_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_event_cnt: got %0d, expected 0", event_cnt_o);
    end
    rst_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (press_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_idle_press: got %0d presses, expected 0", press_q.size());
    end
    clear_log();
  endtask

  task automatic test_short();
    int rise_edge, rel_edge;
    do_reset();
    rise_edge = cyc + 1;
    signal_i = 1'b1;
    tick();
    checks++;
    if (held_o !== 1'b1) begin
      errors++;
      $display("FAIL short_held: got %b, expected 1", held_o);
    end
    repeat (2) tick();
    rel_edge = cyc + 1;
    signal_i = 1'b0;
    repeat (12) tick();
    checks++;
    if (press_q.size() !== 1 || press_q[0] !== rise_edge) begin
      errors++;
      $display("FAIL short_press: got n=%0d at %0d, expected n=1 at %0d",
               press_q.size(), press_q[0], rise_edge);
    end
    checks++;
    if (short_q.size() !== 1 || short_q[0] !== rel_edge + 6) begin
      errors++;
      $display("FAIL short_pulse: got n=%0d at %0d, expected n=1 at %0d",
               short_q.size(), short_q[0], rel_edge + 6);
    end
    checks++;
    if (long_q.size() !== 0 || double_q.size() !== 0) begin
      errors++;
      $display("FAIL short_no_other: got long=%0d double=%0d, expected 0 0",
               long_q.size(), double_q.size());
    end
    checks++;
    if (event_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL short_event_cnt: got %0d, expected 1", event_cnt_o);
    end
    checks++;
    if (held_o !== 1'b0) begin
      errors++;
      $display("FAIL short_released_held: got %b, expected 0", held_o);
    end
  endtask

  task automatic test_long();
    int rise_edge;
    do_reset();
    rise_edge = cyc + 1;
    signal_i = 1'b1;
    repeat (20) tick();
    checks++;
    if (held_o !== 1'b1) begin
      errors++;
      $display("FAIL long_held: got %b, expected 1", held_o);
    end
    signal_i = 1'b0;
    repeat (10) tick();
    checks++;
    if (press_q.size() !== 1 || press_q[0] !== rise_edge) begin
      errors++;
      $display("FAIL long_press: got n=%0d at %0d, expected n=1 at %0d",
               press_q.size(), press_q[0], rise_edge);
    end
    checks++;
    if (long_q.size() !== 1 || long_q[0] !== rise_edge + 10) begin
      errors++;
      $display("FAIL long_pulse: got n=%0d at %0d, expected n=1 at %0d",
               long_q.size(), long_q[0], rise_edge + 10);
    end
    checks++;
    if (short_q.size() !== 0 || double_q.size() !== 0) begin
      errors++;
      $display("FAIL long_no_other: got short=%0d double=%0d, expected 0 0",
               short_q.size(), double_q.size());
    end
    checks++;
    if (event_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL long_event_cnt: got %0d, expected 1", event_cnt_o);
    end
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    checks++;
    if (repeat_q.size() !== 2 || repeat_q[0] !== rise_edge + 14 ||
        repeat_q[1] !== rise_edge + 18) begin
      errors++;
      $display("FAIL long_repeat: got n=%0d at %0d,%0d, expected n=2 at %0d,%0d",
               repeat_q.size(), repeat_q[0], repeat_q[1], rise_edge + 14, rise_edge + 18);
    end
`else
    checks++;
    if (repeat_q.size() !== 0) begin
      errors++;
      $display("FAIL long_repeat_off: got %0d repeats, expected 0", repeat_q.size());
    end
`endif
  endtask

  task automatic test_double();
    int e0;
    do_reset();
    e0 = cyc + 1;
    signal_i = 1'b1;
    repeat (2) tick();
    signal_i = 1'b0;
    repeat (3) tick();
    signal_i = 1'b1;
    repeat (2) tick();
    signal_i = 1'b0;
    repeat (10) tick();
    checks++;
    if (press_q.size() !== 2 || press_q[0] !== e0 || press_q[1] !== e0 + 5) begin
      errors++;
      $display("FAIL double_press: got n=%0d at %0d,%0d, expected n=2 at %0d,%0d",
               press_q.size(), press_q[0], press_q[1], e0, e0 + 5);
    end
    checks++;
    if (double_q.size() !== 1 || double_q[0] !== e0 + 7) begin
      errors++;
      $display("FAIL double_pulse: got n=%0d at %0d, expected n=1 at %0d",
               double_q.size(), double_q[0], e0 + 7);
    end
    checks++;
    if (short_q.size() !== 0 || long_q.size() !== 0) begin
      errors++;
      $display("FAIL double_no_other: got short=%0d long=%0d, expected 0 0",
               short_q.size(), long_q.size());
    end
    checks++;
    if (event_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL double_event_cnt: got %0d, expected 1", event_cnt_o);
    end
  endtask

  task automatic test_timeout_rise();
    int e0;
    do_reset();
    e0 = cyc + 1;
    signal_i = 1'b1;
    repeat (2) tick();
    signal_i = 1'b0;
    repeat (6) tick();
    signal_i = 1'b1;
    repeat (2) tick();
    signal_i = 1'b0;
    repeat (10) tick();
    checks++;
    if (press_q.size() !== 2 || press_q[1] !== e0 + 8) begin
      errors++;
      $display("FAIL edge_press: got n=%0d second at %0d, expected n=2 second at %0d",
               press_q.size(), press_q[1], e0 + 8);
    end
    checks++;
    if (double_q.size() !== 1 || double_q[0] !== e0 + 10) begin
      errors++;
      $display("FAIL edge_double: got n=%0d at %0d, expected n=1 at %0d",
               double_q.size(), double_q[0], e0 + 10);
    end
    checks++;
    if (short_q.size() !== 0) begin
      errors++;
      $display("FAIL edge_no_short: got %0d, expected 0", short_q.size());
    end
    checks++;
    if (event_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL edge_event_cnt: got %0d, expected 1", event_cnt_o);
    end
  endtask

  // Entered with event_cnt_o nonzero so the reset clear is observable.
  task automatic test_reset_mid();
    int rise_edge;
    clear_log();
    signal_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    checks++;
    if ({press_o, short_o, long_o, double_o, repeat_o, held_o} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_pulses: got %b, expected 000000",
               {press_o, short_o, long_o, double_o, repeat_o, held_o});
    end
    checks++;
    if (event_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL midrst_event_cnt: got %0d, expected 0", event_cnt_o);
    end
    rst_i = 1'b0;
    clear_log();
    repeat (15) tick();
    checks++;
    if (press_q.size() !== 0 || long_q.size() !== 0 || held_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_held_through: got press=%0d long=%0d held=%b, expected 0 0 0",
               press_q.size(), long_q.size(), held_o);
    end
    signal_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (short_q.size() !== 0 || event_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL midrst_release: got short=%0d cnt=%0d, expected 0 0",
               short_q.size(), event_cnt_o);
    end
    rise_edge = cyc + 1;
    signal_i = 1'b1;
    tick();
    checks++;
    if (press_q.size() !== 1 || press_q[0] !== rise_edge || held_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_repress: got n=%0d at %0d held=%b, expected n=1 at %0d held=1",
               press_q.size(), press_q[0], held_o, rise_edge);
    end
    signal_i = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      signal_i = 1'b1;
      tick();
      signal_i = 1'b0;
      repeat (8) tick();
      if (i == 254) begin
        checks++;
        if (event_cnt_o !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: got %0d, expected 255", event_cnt_o);
        end
      end
    end
    checks++;
    if (event_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL wrap_zero: got %0d, expected 0", event_cnt_o);
    end
    checks++;
    if (short_q.size() !== 256) begin
      errors++;
      $display("FAIL wrap_shorts: got %0d, expected 256", short_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_timeout_rise();
    test_reset_mid();
    test_wrap();
    checks++;
    if (multi_hot !== 0) begin
      errors++;
      $display("FAIL one_hot_events: got %0d overlapping cycles, expected 0", multi_hot);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
